alu_arbiter: RTL

- Shares one instance of the 32-bit single-cycle ALU (AND/OR/ADD/SUB/SLT/ROR, f[3] selects inverted-b) between NREQ requesters.
- Round-robin grant, registered operands and registered result, valid/ready handshake on both sides.
- Sits between the multi-issue control path (e.g. main datapath plus a coprocessor/address unit) and the shared ALU.

---
 rtl/alu_arb_pkg.sv | 33 +++
 rtl/alu.sv | 36 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter and its ALU.
// The illegal-function checker is enabled by defining ALU_ARB_ILLEGAL_F_EN.
package alu_arb_pkg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned FW        = 4;
   localparam int unsigned NREQ_MAX  = 4;
   localparam int unsigned F_SUB_BIT = 3;

   localparam logic [2:0] F_AND = 3'b000;
   localparam logic [2:0] F_OR  = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SLT = 3'b011;
   localparam logic [2:0] F_ROR = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [FW-1:0]    f;
   } alu_op_t;

   // Operation codes above ROR have no ALU meaning.
   function automatic logic f_illegal(input logic [2:0] op);
      return op > F_ROR;
   endfunction

endpackage

// File: rtl/alu.sv
// 32-bit single-cycle ALU: AND/OR/ADD/SLT/ROR, f[3] selects inverted b (and +1 carry-in).
module alu
   import alu_arb_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [FW-1:0]    f,
   output logic [WIDTH-1:0] y,
   output logic             zero
);

   logic [WIDTH-1:0] bb;
   logic [WIDTH-1:0] sum;
   logic [4:0]       sh;
   logic [4:0]       shl;

   assign bb   = f[F_SUB_BIT] ? ~b : b;
   assign sum  = a + bb + WIDTH'(f[F_SUB_BIT]);
   assign sh   = a[4:0];
   assign shl  = 5'd0 - sh;

   always_comb begin
      y = 'x;
      unique case (f[2:0])
         F_AND:   y = a & bb;
         F_OR:    y = a | bb;
         F_ADD:   y = sum;
         F_SLT:   y = WIDTH'(sum[WIDTH-1]);
         F_ROR:   y = (bb >> sh) | (bb << shl);
         default: y = 'x;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]                        valid,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   output logic [N-1:0]                        grant_c,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx_c
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] idx;

   // Walk from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      idx         = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % int'(N));
         if (valid[idx]) begin
            grant_c     = N'(1) << idx;
            grant_idx_c = idx;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters, registered operands and result.
// Define ALU_ARB_ILLEGAL_F_EN to flag f[2:0] in 101..111 via resp_err with a forced zero result.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0][WIDTH-1:0] req_a,
   input  logic [NREQ-1:0][WIDTH-1:0] req_b,
   input  logic [NREQ-1:0][FW-1:0]    req_f,
   output logic [NREQ-1:0]            resp_valid,
   input  logic [NREQ-1:0]            resp_ready,
   output logic [WIDTH-1:0]           resp_y,
   output logic                       resp_zero,
   output logic                       resp_err
);

   localparam int unsigned PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("alu_arbiter: NREQ must be in 2..%0d", NREQ_MAX);
   end

   state_e        state_q, state_d;
   alu_op_t       op_q;
   logic [PW-1:0] own_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_next;
   logic          armed_q;
   logic [NREQ-1:0] grant_c;
   logic [PW-1:0]   grant_idx_c;
   logic          accept_c;
   logic          done_c;
   logic [WIDTH-1:0] alu_y;
   logic          alu_zero;

   rr_arbiter #(.N(NREQ)) u_rr (
      .valid       (req_valid),
      .ptr         (ptr_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c)
   );

   alu u_alu (
      .a    (op_q.a),
      .b    (op_q.b),
      .f    (op_q.f),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // armed_q keeps req_ready low while reset is held and until the first clock after release.
   assign accept_c  = (state_q == IDLE) && armed_q && (|req_valid);
   assign req_ready = accept_c ? grant_c : '0;
   assign done_c    = (state_q == RESP) && resp_ready[own_q];
   assign ptr_next  = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept_c) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (done_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef ALU_ARB_ILLEGAL_F_EN
   logic illegal_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         armed_q    <= 1'b0;
         op_q       <= '0;
         own_q      <= '0;
         ptr_q      <= '0;
         resp_valid <= '0;
         resp_y     <= '0;
         resp_zero  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_F_EN
         resp_err   <= 1'b0;
         illegal_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         if (accept_c) begin
            op_q  <= '{a: req_a[grant_idx_c], b: req_b[grant_idx_c], f: req_f[grant_idx_c]};
            own_q <= grant_idx_c;
`ifdef ALU_ARB_ILLEGAL_F_EN
            illegal_q <= f_illegal(req_f[grant_idx_c][2:0]);
`endif
         end
         if (state_q == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_F_EN
            resp_y    <= illegal_q ? '0 : alu_y;
            resp_zero <= illegal_q ? 1'b1 : alu_zero;
            resp_err  <= illegal_q;
`else
            resp_y    <= alu_y;
            resp_zero <= alu_zero;
`endif
            resp_valid <= NREQ'(1) << own_q;
         end
         // Pointer moves past the owner only once its result has been taken.
         if (done_c) begin
            resp_valid <= '0;
            ptr_q      <= ptr_next;
         end
      end
   end

`ifndef ALU_ARB_ILLEGAL_F_EN
   assign resp_err = 1'b0;
`endif

endmodule
